// File: rtl/prefetch_ctrl.sv
// prefetch_ctrl: fetch-side producer for the realign buffer.
// Issues word-aligned reads on the instruction port (req/gnt/rvalid), stages the
// in-order responses in a small skid FIFO and writes them into the realign buffer
// one word per cycle. A branch clears the buffer, sets its halfword read offset and
// drops every response still in flight for the old stream.
// Ports:
//   clk, rst_n                                clock, asynchronous active-low reset
//   branch_i, branch_addr_i                   redirect strobe and halfword target
//   buf_full_i                                realign buffer cannot accept a word
//   buf_clear_o, buf_read_offset_o            realign buffer clear / start halfword
//   buf_write_en_o, buf_instr_o, buf_addr_o   realign buffer write port
//   instr_req_o, instr_addr_o, instr_gnt_i    memory request channel
//   instr_rvalid_i, instr_rdata_i             memory response channel (in order)
//   busy_o                                    some granted request still unanswered
module prefetch_ctrl #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        buf_full_i,
    output logic        buf_clear_o,
    output logic        buf_read_offset_o,
    output logic        buf_write_en_o,
    output logic [31:0] buf_instr_o,
    output logic [31:0] buf_addr_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o
);

    localparam int unsigned OW        = 2;
    localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] BOOT_WORD = BOOT_ADDR & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {ST_BOOT, ST_ISSUE, ST_WAIT_GNT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } entry_t;

    state_t        state, state_next;
    logic [OW-1:0] outst, outst_next, discard;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] rd_ptr, wr_ptr;
    entry_t        fifo_mem [FIFO_DEPTH];
    logic [31:0]   fetch_addr, resp_addr, req_addr, target;
    logic          stale;
    logic          branch, credit, fire, drop, push, pop, late_drop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // A redirect is ignored during the single boot cycle
    assign branch = branch_i && (state != ST_BOOT);
    assign target = branch_addr_i & 32'hFFFF_FFFC;

    // Only issue when the response is guaranteed a FIFO slot
    assign credit = (32'(outst) < MAX_OUTSTANDING) &&
                    (32'(outst) + 32'(fifo_cnt) < FIFO_DEPTH);

    // Next-state and request/clear outputs
    always_comb begin
        state_next        = state;
        instr_req_o       = 1'b0;
        instr_addr_o      = fetch_addr;
        buf_clear_o       = 1'b0;
        buf_read_offset_o = 1'b0;
        case (state)
            ST_BOOT: begin
                // Gated so the clear is not shown while reset is held
                buf_clear_o       = rst_n;
                buf_read_offset_o = BOOT_ADDR[1] & rst_n;
                state_next        = ST_ISSUE;
            end
            ST_ISSUE: begin
                instr_req_o = credit;
                if (credit && !instr_gnt_i) state_next = ST_WAIT_GNT;
            end
            ST_WAIT_GNT: begin
                instr_req_o  = 1'b1;
                instr_addr_o = req_addr;
                if (instr_gnt_i) state_next = ST_ISSUE;
            end
            default: state_next = ST_BOOT;
        endcase
        if (branch) begin
            buf_clear_o       = 1'b1;
            buf_read_offset_o = branch_addr_i[1];
        end
    end

    assign fire       = instr_req_o && instr_gnt_i;
    assign outst_next = outst + OW'(fire) - OW'(instr_rvalid_i);
    assign drop       = instr_rvalid_i && (branch || (discard != '0));
    assign push       = instr_rvalid_i && !drop;
    // Held request that was overtaken by a branch: its response belongs to the old stream
    assign late_drop  = (state == ST_WAIT_GNT) && instr_gnt_i && stale;

    assign buf_write_en_o = (fifo_cnt != '0) && !buf_full_i && !branch;
    assign pop            = buf_write_en_o;
    assign buf_instr_o    = fifo_mem[rd_ptr].instr;
    assign buf_addr_o     = fifo_mem[rd_ptr].addr;
    assign busy_o         = (outst != '0);

    // State, counters and address pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            outst      <= '0;
            discard    <= '0;
            fifo_cnt   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fetch_addr <= BOOT_WORD;
            resp_addr  <= BOOT_WORD;
            req_addr   <= BOOT_WORD;
            stale      <= 1'b0;
        end else begin
            state <= state_next;
            outst <= outst_next;
            stale <= (state_next == ST_WAIT_GNT) &&
                     (branch || ((state == ST_WAIT_GNT) && stale));
            if ((state == ST_ISSUE) && instr_req_o && !instr_gnt_i) req_addr <= fetch_addr;
            if (branch) begin
                discard    <= outst_next;
                fetch_addr <= target;
                resp_addr  <= target;
                fifo_cnt   <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                discard <= discard - OW'(drop) + OW'(late_drop);
                if (fire && !((state == ST_WAIT_GNT) && stale)) fetch_addr <= fetch_addr + 32'd4;
                if (push) begin
                    resp_addr <= resp_addr + 32'd4;
                    wr_ptr    <= ptr_inc(wr_ptr);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            end
        end
    end

    // Skid FIFO storage
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {instr_rdata_i, resp_addr};
    end

    // The credit rule must keep the FIFO from overflowing
    always_ff @(posedge clk) begin
        if (rst_n && push && !pop) assert (32'(fifo_cnt) < FIFO_DEPTH);
    end

endmodule

// File: tb/tb_prefetch_ctrl.sv
module tb_prefetch_ctrl;

    localparam int unsigned  MAXO  = 2;
    localparam int unsigned  DEPTH = 2;
    localparam logic [31:0]  BOOT  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        buf_full_i = 1'b0;
    logic        buf_clear_o, buf_read_offset_o, buf_write_en_o;
    logic [31:0] buf_instr_o, buf_addr_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        busy_o;

    prefetch_ctrl #(.MAX_OUTSTANDING(MAXO), .FIFO_DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
        .clk(clk), .rst_n(rst_n), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .buf_full_i(buf_full_i), .buf_clear_o(buf_clear_o), .buf_read_offset_o(buf_read_offset_o),
        .buf_write_en_o(buf_write_en_o), .buf_instr_o(buf_instr_o), .buf_addr_o(buf_addr_o),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } req_t;

    req_t        mq[$];          // granted requests awaiting response, with stream epoch
    logic [31:0] granted[$];     // addresses of all granted requests since reset
    int          epoch, req_epoch, pend, writes, tot_writes;
    logic [31:0] f_exp, w_exp, held_addr, first_waddr;
    logic        boot, prev_wait;
    logic        s_req, s_we, s_clr, s_off;
    logic [31:0] s_addr;

    task automatic do_reset();
        rst_n          = 1'b0;
        branch_i       = 1'b0;
        branch_addr_i  = '0;
        buf_full_i     = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_req", instr_req_o, 1'b0);
        chk1("rst_we", buf_write_en_o, 1'b0);
        chk1("rst_clear", buf_clear_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        rst_n = 1'b1;
        mq.delete();
        granted.delete();
        epoch = 0; req_epoch = 0; pend = 0; writes = 0;
        f_exp = BOOT; w_exp = BOOT; first_waddr = '0;
        boot = 1'b1; prev_wait = 1'b0; held_addr = '0;
    endtask

    // One clock cycle against the model; called at posedge+1, returns at next posedge+1
    task automatic cycle(input logic g, input logic rv, input logic br,
                         input logic [31:0] ba, input logic full);
        logic br_eff, exp_req, exp_we;
        req_t r;
        instr_gnt_i    = g;
        branch_i       = br;
        branch_addr_i  = ba;
        buf_full_i     = full;
        instr_rvalid_i = rv && (mq.size() != 0);
        instr_rdata_i  = instr_rvalid_i ? mem_data(mq[0].addr) : 32'h0;
        #1;
        s_req = instr_req_o; s_addr = instr_addr_o; s_we = buf_write_en_o;
        s_clr = buf_clear_o; s_off = buf_read_offset_o;
        br_eff = br && !boot;

        chk1("clear", buf_clear_o, boot || br_eff);
        chk1("offset", buf_read_offset_o, boot ? BOOT[1] : (br_eff && ba[1]));
        chk1("busy", busy_o, mq.size() != 0);
        if (prev_wait) begin
            chk1("held_req", instr_req_o, 1'b1);
            chk32("held_addr", instr_addr_o, held_addr);
        end else begin
            exp_req = !boot && (mq.size() < MAXO) && (mq.size() + pend < DEPTH);
            chk1("req", instr_req_o, exp_req);
            if (instr_req_o) chk32("req_addr", instr_addr_o, f_exp);
        end
        exp_we = (pend > 0) && !full && !br_eff;
        chk1("write_en", buf_write_en_o, exp_we);
        if (buf_write_en_o) begin
            chk32("write_addr", buf_addr_o, w_exp);
            chk32("write_data", buf_instr_o, mem_data(w_exp));
            if (writes == 0) first_waddr = buf_addr_o;
            writes++;
            tot_writes++;
        end

        // responses: accepted only when from the current stream and no branch now
        if (instr_rvalid_i) begin
            r = mq.pop_front();
            if ((r.epoch == epoch) && !br_eff) pend++;
        end
        if (exp_we) begin
            pend--;
            w_exp = w_exp + 32'd4;
        end
        if (instr_req_o && !prev_wait) req_epoch = epoch;
        if (instr_req_o && g) begin
            mq.push_back('{addr: instr_addr_o, epoch: req_epoch});
            granted.push_back(instr_addr_o);
            if (req_epoch == epoch) f_exp = f_exp + 32'd4;
        end
        prev_wait = instr_req_o && !g;
        held_addr = instr_addr_o;
        if (br_eff) begin
            epoch++;
            pend  = 0;
            f_exp = ba & 32'hFFFF_FFFC;
            w_exp = ba & 32'hFFFF_FFFC;
        end
        boot = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        gnt, rv, full;
        logic [31:0] rdata;
        logic        req, clear, we, busy;
        logic [31:0] iaddr, waddr;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic full,
                                input logic req, input logic [31:0] ia, input logic clr,
                                input logic we, input logic [31:0] wa, input logic busy,
                                input logic [31:0] rd_addr);
        vec_t v;
        v.gnt = g; v.rv = rv; v.full = full; v.rdata = mem_data(rd_addr);
        v.req = req; v.iaddr = ia; v.clear = clr; v.we = we; v.waddr = wa; v.busy = busy;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        logic found;
        tot_writes = 0;
        // boot from 0x100, gnt always, rvalid one cycle after grant; then buffer full
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0);
        tbl[1]  = mk(1, 0, 0, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0);
        tbl[2]  = mk(1, 1, 0, 1, 32'h104, 0, 0, 32'h0,   1, 32'h100);
        tbl[3]  = mk(1, 1, 0, 0, 32'h0,   0, 1, 32'h100, 1, 32'h104);
        tbl[4]  = mk(1, 0, 0, 1, 32'h108, 0, 1, 32'h104, 0, 32'h0);
        tbl[5]  = mk(1, 1, 0, 1, 32'h10C, 0, 0, 32'h0,   1, 32'h108);
        tbl[6]  = mk(1, 1, 0, 0, 32'h0,   0, 1, 32'h108, 1, 32'h10C);
        tbl[7]  = mk(1, 0, 0, 1, 32'h110, 0, 1, 32'h10C, 0, 32'h0);
        tbl[8]  = mk(1, 1, 1, 1, 32'h114, 0, 0, 32'h0,   1, 32'h110);
        tbl[9]  = mk(1, 1, 1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h114);
        tbl[10] = mk(1, 0, 1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0);
        tbl[11] = mk(1, 0, 0, 0, 32'h0,   0, 1, 32'h110, 0, 32'h0);
        tbl[12] = mk(1, 0, 0, 1, 32'h118, 0, 1, 32'h114, 0, 32'h0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            instr_gnt_i    = tbl[i].gnt;
            instr_rvalid_i = tbl[i].rv;
            instr_rdata_i  = tbl[i].rv ? tbl[i].rdata : 32'h0;
            buf_full_i     = tbl[i].full;
            branch_i       = 1'b0;
            #1;
            chk1($sformatf("t1_req[%0d]", i), instr_req_o, tbl[i].req);
            if (tbl[i].req) chk32($sformatf("t1_addr[%0d]", i), instr_addr_o, tbl[i].iaddr);
            chk1($sformatf("t1_clear[%0d]", i), buf_clear_o, tbl[i].clear);
            chk1($sformatf("t1_we[%0d]", i), buf_write_en_o, tbl[i].we);
            chk1($sformatf("t1_busy[%0d]", i), busy_o, tbl[i].busy);
            if (tbl[i].we) begin
                chk32($sformatf("t1_waddr[%0d]", i), buf_addr_o, tbl[i].waddr);
                chk32($sformatf("t1_wdata[%0d]", i), buf_instr_o, mem_data(tbl[i].waddr));
            end
            @(posedge clk);
            #1;
        end

        // branch to 0x2002 with two requests outstanding (reset abandons the table run)
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk1("t3_two_outstanding", mq.size() == 2, 1'b1);
        cycle(1, 0, 1, 32'h0000_2002, 0);
        chk1("t3_clear", s_clr, 1'b1);
        chk1("t3_offset", s_off, 1'b1);
        for (int k = 0; k < 20 && writes == 0; k++) cycle(1, 1, 0, 0, 0);
        chk1("t3_wrote", writes > 0, 1'b1);
        chk32("t3_first_write", first_waddr, 32'h0000_2000);

        // grant withheld 3 cycles, branch in the second
        do_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk32("t4_pending_addr", s_addr, 32'h100);
        cycle(0, 0, 1, 32'h0000_3000, 0);
        chk1("t4_req_held", s_req, 1'b1);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk32("t4_granted_old", s_addr, 32'h100);
        cycle(1, 1, 0, 0, 0);
        chk1("t4_next_req", s_req, 1'b1);
        chk32("t4_next_addr", s_addr, 32'h0000_3000);
        for (int k = 0; k < 20 && writes == 0; k++) cycle(1, 1, 0, 0, 0);
        chk32("t4_first_write", first_waddr, 32'h0000_3000);

        // branch coincident with rvalid and a pending write
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        chk1("t5_pending", pend == 1 && mq.size() == 1, 1'b1);
        cycle(1, 1, 1, 32'h0000_4000, 0);
        chk1("t5_we_suppressed", s_we, 1'b0);
        cycle(0, 0, 0, 0, 0);
        chk1("t5_fifo_empty", s_we, 1'b0);

        // fetch across the top of the address space
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 32'hFFFF_FFF8, 0);
        for (int k = 0; k < 16; k++) cycle(1, 1, 0, 0, 0);
        found = 1'b0;
        idx = 0;
        foreach (granted[j]) if (!found && granted[j] == 32'hFFFF_FFFC) begin
            found = 1'b1;
            idx = j;
        end
        chk1("t6_reached_top", found && (idx + 1 < granted.size()), 1'b1);
        if (found && (idx + 1 < granted.size())) chk32("t6_wrap_addr", granted[idx + 1], 32'h0);

        // randomized traffic against the model
        tot_writes = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] ba;
            if (i == 2000) do_reset();
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 7) * 2))
                                             : ($urandom & 32'hFFFF_FFFE);
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
                  ba, $urandom_range(0, 9) < 2);
        end
        for (int k = 0; k < 30; k++) cycle(1, 1, 0, 0, 0);
        chk1("rand_progress", tot_writes > 300, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
